ysyx_25020037_clint: RTL and testbench

//  AXI4 read-only responder for the core-local timer (CLINT) window 0x0200_0000-0x0200_FFFF.

---
 rtl/ysyx_25020037_clint_pkg.sv | 55 +++++
 rtl/ysyx_25020037_clint_timer.sv | 32 +++
 rtl/ysyx_25020037_clint.sv | 111 +++++++++++
 tb/tb_ysyx_25020037_clint.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25020037_clint_pkg.sv
// Shared constants, request/beat types and the per-beat register decode
// for the CLINT mtime read responder.
package ysyx_25020037_clint_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [15:0] CLINT_BASE        = 16'h0200;
    localparam logic [15:0] MTIME_OFF_DEFAULT = 16'hBFF8;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } beat_t;

    // Word-granular decode: byte lane bits are ignored so narrow reads
    // return the whole aligned word.
    function automatic beat_t beat_decode(input logic [15:0] addr,
                                          input logic        bad,
                                          input logic [63:0] snap,
                                          input logic [15:0] off);
        beat_t       b;
        logic [15:0] off_hi;
        off_hi = off + 16'd4;
        b.data = '0;
        b.resp = RESP_SLVERR;
        if (!bad) begin
            if (addr[15:2] == off[15:2]) begin
                b.data = snap[31:0];
                b.resp = RESP_OKAY;
            end else if (addr[15:2] == off_hi[15:2]) begin
                b.data = snap[63:32];
                b.resp = RESP_OKAY;
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/ysyx_25020037_clint_timer.sv
// Free-running 64-bit mtime counter with a prescaler; never stalls and
// wraps silently at 2^64.
module ysyx_25020037_clint_timer #(
    parameter int TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] mtime
);

    localparam logic [31:0] DIV_MAX = 32'(TICK_DIV - 1);

    logic [31:0] div;
    logic [63:0] cnt;
    logic        tick;

    assign tick  = (div == DIV_MAX);
    assign mtime = cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
            cnt <= '0;
        end else if (tick) begin
            div <= '0;
            cnt <= cnt + 64'd1;
        end else begin
            div <= div + 32'd1;
        end
    end

endmodule

// File: rtl/ysyx_25020037_clint.sv
// AXI4 read-only responder for the CLINT window: serves bursts of the
// 64-bit mtime counter from a snapshot taken at address acceptance.
module ysyx_25020037_clint
    import ysyx_25020037_clint_pkg::*;
#(
    parameter logic [15:0] MTIME_OFF = MTIME_OFF_DEFAULT,
    parameter int          TICK_DIV  = 1,
    parameter int          ID_W      = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            arvalid,
    output logic            arready,
    input  logic [31:0]     araddr,
    input  logic [ID_W-1:0] arid,
    input  logic [7:0]      arlen,
    input  logic [2:0]      arsize,
    input  logic [1:0]      arburst,
    output logic            rvalid,
    input  logic            rready,
    output logic [31:0]     rdata,
    output logic [1:0]      rresp,
    output logic            rlast,
    output logic [ID_W-1:0] rid,
    output logic [63:0]     mtime
);

    state_t      state, nxt;
    req_t        req;
    logic [7:0]  beat_cnt;
    logic [63:0] snap;
    logic        bad;
    logic        ar_hs, r_hs, last_beat, ar_bad;
    logic [15:0] nxt_addr;
    beat_t       ar_beat, nxt_beat;
    logic        unused_addr_hi;

    ysyx_25020037_clint_timer #(.TICK_DIV(TICK_DIV)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .mtime (mtime)
    );

    assign rvalid    = (state == RESP);
    assign ar_hs     = arvalid && arready && (state == IDLE);
    assign r_hs      = rvalid && rready;
    assign last_beat = (beat_cnt == req.len);
    // Oversized beats and WRAP/reserved bursts poison the whole burst.
    assign ar_bad    = (arsize > 3'd2) || arburst[1];
    assign nxt_addr  = (req.burst == BURST_INCR) ? req.addr + 16'd4 : req.addr;

    // The first beat decodes against the live counter, which is exactly
    // the value being captured into snap on the same edge.
    assign ar_beat  = beat_decode(araddr[15:0], ar_bad, mtime, MTIME_OFF);
    assign nxt_beat = beat_decode(nxt_addr, bad, snap, MTIME_OFF);

    assign unused_addr_hi = ^araddr[31:16];

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (ar_hs) nxt = RESP;
            RESP:    if (r_hs && last_beat) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            arready  <= 1'b0;
            req      <= '0;
            beat_cnt <= '0;
            snap     <= '0;
            bad      <= 1'b0;
            rdata    <= '0;
            rresp    <= '0;
            rlast    <= 1'b0;
            rid      <= '0;
        end else begin
            state   <= nxt;
            // Registered so the cycle after the last beat is the earliest
            // possible acceptance of the next address.
            arready <= (nxt == IDLE);
            if (ar_hs) begin
                req.addr  <= araddr[15:0];
                req.len   <= arlen;
                req.size  <= arsize;
                req.burst <= arburst;
                bad       <= ar_bad;
                beat_cnt  <= '0;
                snap      <= mtime;
                rdata     <= ar_beat.data;
                rresp     <= ar_beat.resp;
                rlast     <= (arlen == 8'd0);
                rid       <= arid;
            end else if (r_hs) begin
                if (!last_beat) begin
                    req.addr <= nxt_addr;
                    beat_cnt <= beat_cnt + 8'd1;
                    rdata    <= nxt_beat.data;
                    rresp    <= nxt_beat.resp;
                    rlast    <= ((beat_cnt + 8'd1) == req.len);
                end else begin
                    rlast <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25020037_clint.sv
// Randomized bench for the CLINT responder against a cycle-count model of
// mtime and a per-beat rule model of the read channel.
module tb_ysyx_25020037_clint;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;
    localparam logic [1:0] OKAY  = 2'b00;
    localparam logic [1:0] SLV   = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic        arvalid;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rready;

    logic        arready, rvalid, rlast;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [3:0]  rid;
    logic [63:0] mtime;

    logic        unused4_arready, unused4_rvalid, unused4_rlast;
    logic [31:0] unused4_rdata;
    logic [1:0]  unused4_rresp;
    logic [3:0]  unused4_rid;
    logic [63:0] mtime4;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] cyc;
    logic [63:0] mt_off;
    logic        chk_mt;

    always #5 clk = ~clk;

    ysyx_25020037_clint #(.TICK_DIV(1)) dut (
        .clk(clk), .rst(rst), .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rid(rid), .mtime(mtime)
    );

    ysyx_25020037_clint #(.TICK_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .arvalid(arvalid), .arready(unused4_arready), .araddr(araddr),
        .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(unused4_rvalid), .rready(rready), .rdata(unused4_rdata), .rresp(unused4_rresp),
        .rlast(unused4_rlast), .rid(unused4_rid), .mtime(mtime4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference time: cycles elapsed since reset, plus any preload offset.
    always @(posedge clk) begin
        if (rst) cyc <= 64'd0;
        else     cyc <= cyc + 64'd1;
    end

    always @(negedge clk) begin
        if (chk_mt && !rst) begin
            check("mtime", mtime, cyc + mt_off);
            check("mtime_div4", mtime4, cyc / 64'd4);
        end
    end

    // {resp, data} a beat at byte offset a must carry, given the snapshot.
    function automatic logic [33:0] exp_beat(input logic [15:0] a, input logic bad,
                                             input logic [63:0] s);
        logic [15:0] w;
        w = a & 16'hFFFC;
        if (bad)               return {SLV, 32'h0};
        else if (w == 16'hBFF8) return {OKAY, s[31:0]};
        else if (w == 16'hBFFC) return {OKAY, s[63:32]};
        else                   return {SLV, 32'h0};
    endfunction

    task automatic rd(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                      input logic [1:0] bu, input logic [3:0] id, input int stall_at);
        logic [63:0] snap;
        logic        bad;
        logic [15:0] ad;
        logic [33:0] e;
        int          w;
        araddr = a; arlen = len; arsize = sz; arburst = bu; arid = id;
        arvalid = 1'b1; rready = 1'b1;
        w = 0;
        while (!arready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!arready) begin
            check("ar_timeout", 64'(arready), 64'd1);
            arvalid = 1'b0;
            return;
        end
        snap = cyc + mt_off;
        @(negedge clk);
        arvalid = 1'b0;
        bad = (sz > 3'd2) || (bu == WRAP) || (bu == 2'b11);
        ad = a[15:0];
        for (int i = 0; i <= int'(len); i++) begin
            e = exp_beat(ad, bad, snap);
            check("rvalid", 64'(rvalid), 64'd1);
            check("arready_busy", 64'(arready), 64'd0);
            check("rdata", 64'(rdata), 64'(e[31:0]));
            check("rresp", 64'(rresp), 64'(e[33:32]));
            check("rlast", 64'(rlast), 64'(i == int'(len)));
            check("rid", 64'(rid), 64'(id));
            if (i == stall_at) begin
                rready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("hold_rvalid", 64'(rvalid), 64'd1);
                    check("hold_rdata", 64'(rdata), 64'(e[31:0]));
                    check("hold_rresp", 64'(rresp), 64'(e[33:32]));
                    check("hold_rlast", 64'(rlast), 64'(i == int'(len)));
                end
                rready = 1'b1;
            end
            @(negedge clk);
            if (bu == INCR) ad = ad + 16'd4;
        end
        check("rvalid_done", 64'(rvalid), 64'd0);
        check("arready_back", 64'(arready), 64'd1);
    endtask

    task automatic reset_mid;
        int w;
        araddr = 32'h0200_BFF8; arlen = 8'd3; arsize = 3'd2; arburst = INCR; arid = 4'd7;
        arvalid = 1'b1; rready = 1'b1;
        w = 0;
        while (!arready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("rst_ar_ready", 64'(arready), 64'd1);
        @(negedge clk);
        arvalid = 1'b0;
        @(negedge clk);
        check("rst_beat2_valid", 64'(rvalid), 64'd1);
        chk_mt = 1'b0;
        rst = 1'b1;
        mt_off = 64'd0;
        @(negedge clk);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_mtime", mtime, 64'd0);
        check("rst_arready", 64'(arready), 64'd0);
        check("rst_rlast", 64'(rlast), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        rst = 1'b0;
        chk_mt = 1'b1;
        @(negedge clk);
        check("post_rst_arready", 64'(arready), 64'd1);
        check("post_rst_rvalid", 64'(rvalid), 64'd0);
        rd(32'h0200_BFF8, 8'd0, 3'd2, INCR, 4'd9, -1);
    endtask

    initial begin
        logic [63:0] t0;
        logic [15:0] off;
        logic [7:0]  len;
        int          sel, stall;
        rst = 1'b1; arvalid = 1'b0; araddr = '0; arid = '0; arlen = '0;
        arsize = '0; arburst = '0; rready = 1'b0; chk_mt = 1'b0; mt_off = '0;
        repeat (3) @(negedge clk);
        check("reset_arready", 64'(arready), 64'd0);
        check("reset_rvalid", 64'(rvalid), 64'd0);
        check("reset_rlast", 64'(rlast), 64'd0);
        check("reset_rdata", 64'(rdata), 64'd0);
        check("reset_rresp", 64'(rresp), 64'd0);
        check("reset_rid", 64'(rid), 64'd0);
        check("reset_mtime", mtime, 64'd0);
        check("reset_mtime4", mtime4, 64'd0);
        rst = 1'b0;
        chk_mt = 1'b1;

        // single read after idling
        repeat (10) @(negedge clk);
        rd(32'h0200_BFF8, 8'd0, 3'd2, INCR, 4'd3, -1);

        // preload across the 32-bit carry, then an atomic 2-beat read
        @(negedge clk);
        chk_mt = 1'b0;
        force dut.u_timer.cnt = 64'h0000_0001_FFFF_FFFF;
        mt_off = 64'h0000_0001_FFFF_FFFF - cyc;
        #1 release dut.u_timer.cnt;
        chk_mt = 1'b1;
        rd(32'h0200_BFF8, 8'd1, 3'd2, INCR, 4'd1, -1);

        // error paths
        rd(32'h0200_4000, 8'd0, 3'd2, INCR, 4'd1, -1);
        rd(32'h0200_BFF8, 8'd3, 3'd2, INCR, 4'd2, -1);
        rd(32'h0200_BFF8, 8'd1, 3'd3, INCR, 4'd4, -1);
        rd(32'h0200_BFF8, 8'd1, 3'd2, WRAP, 4'd5, -1);
        rd(32'h0200_BFFC, 8'd2, 3'd2, FIXED, 4'd6, -1);
        rd(32'h0200_BFF9, 8'd1, 3'd0, INCR, 4'd8, -1);

        // backpressure mid-burst
        rd(32'h0200_BFF8, 8'd2, 3'd2, INCR, 4'd5, 1);

        reset_mid();

        // prescaled counter over 40 cycles
        t0 = mtime4;
        repeat (40) @(negedge clk);
        check("div4_40cyc", mtime4 - t0, 64'd10);

        // back-to-back singles
        repeat (3) rd(32'h0200_BFFC, 8'd0, 3'd2, INCR, 4'd2, -1);

        for (int n = 0; n < 40; n++) begin
            sel = int'($urandom_range(0, 4));
            case (sel)
                0:       off = 16'hBFF8;
                1:       off = 16'hBFFC;
                2:       off = 16'hBFF0;
                3:       off = 16'hBFF8 | 16'($urandom_range(0, 3));
                default: off = 16'($urandom);
            endcase
            len = 8'($urandom_range(0, 4));
            stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(len))) : -1;
            rd({16'h0200, off}, len, 3'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               4'($urandom), stall);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

endmodule
